// File: rtl/cm_loader.sv
// cm_loader: streams instruction words into the per-row CGRA context memories.
// A start request picks a set of rows, a base line and a per-row length; every
// accepted stream word turns into one registered memory write on the next cycle.
// Optional feature macro: CM_LOADER_BROADCAST_EN (one pass of len words written
// to every masked row at once when broadcast_i is set with start_i).
module cm_loader #(
  parameter int N_ROW             = 4,
  parameter int IMEM_N_LINES_LOG2 = 5,
  parameter int DATA_WIDTH        = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         start_i,
  input  logic [N_ROW-1:0]             row_mask_i,
  input  logic [IMEM_N_LINES_LOG2-1:0] base_addr_i,
  input  logic [IMEM_N_LINES_LOG2:0]   len_i,
  input  logic                         broadcast_i,
  input  logic                         data_valid_i,
  output logic                         data_ready_o,
  input  logic [DATA_WIDTH-1:0]        data_i,
  output logic [N_ROW-1:0]             cm_row_req_o,
  output logic                         cm_we_o,
  output logic [IMEM_N_LINES_LOG2-1:0] cm_addr_o,
  output logic [DATA_WIDTH-1:0]        cm_wdata_o,
  output logic                         busy_o,
  output logic                         done_o
);

  localparam int AW = IMEM_N_LINES_LOG2;
  localparam int LW = IMEM_N_LINES_LOG2 + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_reg, state_next;

  // Request captured at start; mask_reg shrinks as sequential rows complete.
  logic [N_ROW-1:0]      mask_reg, mask_next;
  logic [AW-1:0]         base_reg, base_next;
  logic [LW-1:0]         len_reg, len_next;
  logic [LW-1:0]         cnt_reg, cnt_next;
  logic                  bcast_reg, bcast_next;

  // Registered memory write port.
  logic                  we_reg, we_next;
  logic [N_ROW-1:0]      row_req_reg, row_req_next;
  logic [AW-1:0]         addr_reg, addr_next;
  logic [DATA_WIDTH-1:0] wdata_reg, wdata_next;

  logic                  bcast_in;
  logic [N_ROW-1:0]      cur_row;
  logic [N_ROW-1:0]      rows_left;
  logic                  accept;
  logic                  last_word;
  logic                  last_row;

`ifdef CM_LOADER_BROADCAST_EN
  assign bcast_in = broadcast_i;
`else
  // Broadcast is not built in: the request bit is deliberately dropped.
  logic unused_broadcast;
  assign unused_broadcast = broadcast_i;
  assign bcast_in         = 1'b0;
`endif

  // Lowest remaining row is the one being loaded (ascending order).
  assign cur_row   = mask_reg & (~mask_reg + N_ROW'(1));
  assign rows_left = mask_reg & ~cur_row;
  assign accept    = (state_reg == LOAD) && data_valid_i;
  assign last_word = (cnt_reg == (len_reg - LW'(1)));
  assign last_row  = bcast_reg || (rows_left == '0);

  assign data_ready_o = (state_reg == LOAD);
  assign busy_o       = (state_reg != IDLE);
  assign done_o       = (state_reg == DONE);
  assign cm_we_o      = we_reg;
  assign cm_row_req_o = row_req_reg;
  assign cm_addr_o    = addr_reg;
  assign cm_wdata_o   = wdata_reg;

  // Next-state, request capture and write generation.
  always_comb begin
    state_next   = state_reg;
    mask_next    = mask_reg;
    base_next    = base_reg;
    len_next     = len_reg;
    cnt_next     = cnt_reg;
    bcast_next   = bcast_reg;
    we_next      = 1'b0;
    row_req_next = '0;
    addr_next    = addr_reg;
    wdata_next   = wdata_reg;
    case (state_reg)
      IDLE: begin
        if (start_i) begin
          mask_next  = row_mask_i;
          base_next  = base_addr_i;
          len_next   = len_i;
          cnt_next   = '0;
          bcast_next = bcast_in;
          if ((row_mask_i != '0) && (len_i != '0)) begin
            state_next = LOAD;
          end else begin
            state_next = DONE;
          end
        end
      end
      LOAD: begin
        if (accept) begin
          we_next      = 1'b1;
          row_req_next = bcast_reg ? mask_reg : cur_row;
          // Address wraps naturally through the AW-bit adder.
          addr_next    = base_reg + cnt_reg[AW-1:0];
          wdata_next   = data_i;
          if (last_word) begin
            cnt_next = '0;
            if (!bcast_reg) begin
              mask_next = rows_left;
            end
            if (last_row) begin
              state_next = DONE;
            end
          end else begin
            cnt_next = cnt_reg + LW'(1);
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Request bookkeeping and write-port registers; reset clears every output.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mask_reg    <= '0;
      base_reg    <= '0;
      len_reg     <= '0;
      cnt_reg     <= '0;
      bcast_reg   <= 1'b0;
      we_reg      <= 1'b0;
      row_req_reg <= '0;
      addr_reg    <= '0;
      wdata_reg   <= '0;
    end else begin
      mask_reg    <= mask_next;
      base_reg    <= base_next;
      len_reg     <= len_next;
      cnt_reg     <= cnt_next;
      bcast_reg   <= bcast_next;
      we_reg      <= we_next;
      row_req_reg <= row_req_next;
      addr_reg    <= addr_next;
      wdata_reg   <= wdata_next;
    end
  end

endmodule

// File: tb/tb_cm_loader.sv
// Scoreboard bench for cm_loader: expected writes / done pulses are queued when
// a request is issued; a negedge monitor pops and compares each DUT output event.
module tb_cm_loader;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [3:0]  row_mask_i;
  logic [4:0]  base_addr_i;
  logic [5:0]  len_i;
  logic        broadcast_i;
  logic        data_valid_i;
  logic        data_ready_o;
  logic [31:0] data_i;
  logic [3:0]  cm_row_req_o;
  logic        cm_we_o;
  logic [4:0]  cm_addr_o;
  logic [31:0] cm_wdata_o;
  logic        busy_o;
  logic        done_o;

  cm_loader dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .row_mask_i   (row_mask_i),
    .base_addr_i  (base_addr_i),
    .len_i        (len_i),
    .broadcast_i  (broadcast_i),
    .data_valid_i (data_valid_i),
    .data_ready_o (data_ready_o),
    .data_i       (data_i),
    .cm_row_req_o (cm_row_req_o),
    .cm_we_o      (cm_we_o),
    .cm_addr_o    (cm_addr_o),
    .cm_wdata_o   (cm_wdata_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        wr;
    logic [3:0]  row;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        done;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          done_count = 0;
  logic [31:0] words[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic push_wr(input logic [3:0] row, input logic [4:0] addr,
                         input logic [31:0] data, input logic done);
    exp_t e;
    e.wr = 1'b1; e.row = row; e.addr = addr; e.data = data; e.done = done;
    exp_q.push_back(e);
  endtask

  task automatic push_done_only();
    exp_t e;
    e.wr = 1'b0; e.row = 4'b0; e.addr = 5'd0; e.data = 32'd0; e.done = 1'b1;
    exp_q.push_back(e);
  endtask

  // Monitor: every write or done pulse must match the head of the queue.
  always @(negedge clk_i) begin
    if (cm_we_o === 1'b1 || done_o === 1'b1) begin
      if (done_o === 1'b1) done_count++;
      if (exp_q.size() == 0) begin
        chk("unexpected_output", {62'd0, cm_we_o, done_o}, 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        $display("txn we=%0b row=%b addr=%0d data=%08h done=%0b", cm_we_o, cm_row_req_o,
                 cm_addr_o, cm_wdata_o, done_o);
        chk("we", {63'd0, cm_we_o}, {63'd0, e.wr});
        chk("done", {63'd0, done_o}, {63'd0, e.done});
        if (e.wr) begin
          chk("row_req", {60'd0, cm_row_req_o}, {60'd0, e.row});
          chk("addr", {59'd0, cm_addr_o}, {59'd0, e.addr});
          chk("wdata", {32'd0, cm_wdata_o}, {32'd0, e.data});
        end
      end
    end
  end

  // Called #1 after a rising edge; issues a one-cycle start request.
  task automatic do_start(input logic [3:0] mask, input logic [4:0] base,
                          input logic [5:0] len, input logic bc);
    start_i = 1'b1; row_mask_i = mask; base_addr_i = base; len_i = len; broadcast_i = bc;
    @(posedge clk_i); #1;
    start_i = 1'b0;
  endtask

  // Streams the words in 'words'; random_gaps inserts ~50% idle input cycles.
  task automatic send_words(input bit random_gaps);
    foreach (words[k]) begin
      logic rdy;
      int   guard;
      if (random_gaps) begin
        while ($urandom_range(1, 0) == 0) begin
          data_valid_i = 1'b0;
          @(posedge clk_i); #1;
          chk("stall_we", {63'd0, cm_we_o}, 64'd0);
        end
      end
      data_valid_i = 1'b1;
      data_i = words[k];
      guard = 0;
      do begin
        rdy = data_ready_o;
        @(posedge clk_i); #1;
        guard++;
      end while (!rdy && guard < 20);
      if (!rdy) chk("ready_timeout", {63'd0, rdy}, 64'd1);
    end
    data_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (busy_o !== 1'b0 && guard < 50) begin
      @(posedge clk_i); #1;
      guard++;
    end
    chk("idle", {63'd0, busy_o}, 64'd0);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, {63'd0, data_ready_o}, 64'd0);
    chk({tag, "_row"}, {60'd0, cm_row_req_o}, 64'd0);
    chk({tag, "_we"}, {63'd0, cm_we_o}, 64'd0);
    chk({tag, "_addr"}, {59'd0, cm_addr_o}, 64'd0);
    chk({tag, "_wdata"}, {32'd0, cm_wdata_o}, 64'd0);
    chk({tag, "_busy"}, {63'd0, busy_o}, 64'd0);
    chk({tag, "_done"}, {63'd0, done_o}, 64'd0);
  endtask

  initial begin
    int dc;
    rst_i = 1'b1; start_i = 1'b0; row_mask_i = '0; base_addr_i = '0; len_i = '0;
    broadcast_i = 1'b0; data_valid_i = 1'b0; data_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    chk_all_zero("reset");
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    // Two sequential rows, back-to-back stream A..F.
    push_wr(4'b0001, 5'd2, 32'hAAAA_0001, 1'b0);
    push_wr(4'b0001, 5'd3, 32'hBBBB_0002, 1'b0);
    push_wr(4'b0001, 5'd4, 32'hCCCC_0003, 1'b0);
    push_wr(4'b0100, 5'd2, 32'hDDDD_0004, 1'b0);
    push_wr(4'b0100, 5'd3, 32'hEEEE_0005, 1'b0);
    push_wr(4'b0100, 5'd4, 32'hFFFF_0006, 1'b1);
    do_start(4'b0101, 5'd2, 6'd3, 1'b0);
    chk("busy_after_start", {63'd0, busy_o}, 64'd1);
    chk("ready_in_load", {63'd0, data_ready_o}, 64'd1);
    words = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003,
              32'hDDDD_0004, 32'hEEEE_0005, 32'hFFFF_0006};
    send_words(1'b0);
    wait_idle();

    // Address wrap 30,31,0,1.
    push_wr(4'b0001, 5'd30, 32'h0000_0030, 1'b0);
    push_wr(4'b0001, 5'd31, 32'h0000_0031, 1'b0);
    push_wr(4'b0001, 5'd0, 32'h0000_0032, 1'b0);
    push_wr(4'b0001, 5'd1, 32'h0000_0033, 1'b1);
    do_start(4'b0001, 5'd30, 6'd4, 1'b0);
    words = '{32'h0000_0030, 32'h0000_0031, 32'h0000_0032, 32'h0000_0033};
    send_words(1'b0);
    wait_idle();

    // Zero length, then empty mask: done the cycle after start, no writes.
    push_done_only();
    do_start(4'b1111, 5'd4, 6'd0, 1'b0);
    @(negedge clk_i);
    chk("zero_len_done", {63'd0, done_o}, 64'd1);
    chk("zero_len_we", {63'd0, cm_we_o}, 64'd0);
    @(posedge clk_i); #1;
    wait_idle();
    push_done_only();
    do_start(4'b0000, 5'd4, 6'd3, 1'b0);
    @(negedge clk_i);
    chk("empty_mask_done", {63'd0, done_o}, 64'd1);
    chk("empty_mask_we", {63'd0, cm_we_o}, 64'd0);
    @(posedge clk_i); #1;
    wait_idle();

    // All four rows, len 8, random ~50% valid duty.
    words = {};
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 8; i++) begin
        logic [4:0] a;
        a = 5'(5 + i);
        words.push_back(32'h1000_0000 + 32'(r * 8 + i));
        push_wr(4'(1 << r), a, 32'h1000_0000 + 32'(r * 8 + i), (r == 3 && i == 7));
      end
    end
    do_start(4'b1111, 5'd5, 6'd8, 1'b0);
    send_words(1'b1);
    wait_idle();

    // Reset after the 3rd accepted word, then a fresh load.
    push_wr(4'b0001, 5'd0, 32'h5000_0001, 1'b0);
    push_wr(4'b0001, 5'd1, 32'h5000_0002, 1'b0);
    push_wr(4'b0001, 5'd2, 32'h5000_0003, 1'b0);
    do_start(4'b0011, 5'd0, 6'd4, 1'b0);
    words = '{32'h5000_0001, 32'h5000_0002, 32'h5000_0003};
    send_words(1'b0);
    dc = done_count;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    chk_all_zero("midload_reset");
    repeat (5) @(posedge clk_i);
    #1;
    chk("no_done_after_reset", 64'(done_count - dc), 64'd0);
    chk("reset_queue_drained", 64'(exp_q.size()), 64'd0);
    push_wr(4'b0010, 5'd9, 32'h6000_0001, 1'b0);
    push_wr(4'b0010, 5'd10, 32'h6000_0002, 1'b1);
    do_start(4'b0010, 5'd9, 6'd2, 1'b0);
    words = '{32'h6000_0001, 32'h6000_0002};
    send_words(1'b0);
    wait_idle();

    // Broadcast request: mask 1011, len 2.
`ifdef CM_LOADER_BROADCAST_EN
    push_wr(4'b1011, 5'd7, 32'h7000_0001, 1'b0);
    push_wr(4'b1011, 5'd8, 32'h7000_0002, 1'b1);
    words = '{32'h7000_0001, 32'h7000_0002};
`else
    push_wr(4'b0001, 5'd7, 32'h7000_0001, 1'b0);
    push_wr(4'b0001, 5'd8, 32'h7000_0002, 1'b0);
    push_wr(4'b0010, 5'd7, 32'h7000_0003, 1'b0);
    push_wr(4'b0010, 5'd8, 32'h7000_0004, 1'b0);
    push_wr(4'b1000, 5'd7, 32'h7000_0005, 1'b0);
    push_wr(4'b1000, 5'd8, 32'h7000_0006, 1'b1);
    words = '{32'h7000_0001, 32'h7000_0002, 32'h7000_0003,
              32'h7000_0004, 32'h7000_0005, 32'h7000_0006};
`endif
    do_start(4'b1011, 5'd7, 6'd2, 1'b1);
    send_words(1'b0);
    wait_idle();

    repeat (2) @(posedge clk_i);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
